apb_mux_n: RTL and testbench

APB_MUX_N -- requirements
Module: apb_mux_n

---
 rtl/apb_mux_n.sv | 180 ++++++++++++++++++
 tb/tb_apb_mux_n.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_mux_n.sv
// apb_mux_n: one APB master fanned out to NSLV slaves by address decode.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   apb_*_cpu            master side: psel/enab/rw/addr/datai in, datao/ack/err out
//   slv_psel, slv_enab   per-slave select / enable (one-hot or zero)
//   slv_rw/addr/datai    broadcast copies of the master request
//   slv_datao, slv_ack   per-slave read data (packed, slave i at [i*DATA_W +: DATA_W]) / ack
//   err_addr             address of the most recent error completion (sticky)
//
// A transfer whose address hits no slave completes with err on its first
// enable cycle. A selected slave that keeps the master waiting too long is
// cut off by a one-cycle TOUT error completion.

// Single-slave address match: bits set in mask are offset bits and ignored.
module apb_mux_n_dec #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] mask,
  output logic              hit
);
  assign hit = ((addr & ~mask) == base);
endmodule

module apb_mux_n #(
  parameter int                     NSLV     = 9,
  parameter int                     ADDR_W   = 32,
  parameter int                     DATA_W   = 32,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = '0,
  parameter int                     TIMEOUT  = 255
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     apb_psel_cpu,
  input  logic                     apb_enab_cpu,
  input  logic                     apb_rw_cpu,
  input  logic [ADDR_W-1:0]        apb_addr_cpu,
  input  logic [DATA_W-1:0]        apb_datai_cpu,
  output logic [DATA_W-1:0]        apb_datao_cpu,
  output logic                     apb_ack_cpu,
  output logic                     apb_err_cpu,
  output logic [NSLV-1:0]          slv_psel,
  output logic [NSLV-1:0]          slv_enab,
  output logic                     slv_rw,
  output logic [ADDR_W-1:0]        slv_addr,
  output logic [DATA_W-1:0]        slv_datai,
  input  logic [NSLV*DATA_W-1:0]   slv_datao,
  input  logic [NSLV-1:0]          slv_ack,
  output logic [ADDR_W-1:0]        err_addr
);
  localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam bit TOUT_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LIM = TOUT_EN ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, XFER, TOUT} state_t;

  state_t                       state;
  logic [IDX_W-1:0]             idx_q, idx_live;
  logic                         hit_q, hit_live;
  logic [ADDR_W-1:0]            addr_q;
  logic [CNT_W-1:0]             cnt, cnt_inc;
  logic [NSLV-1:0]              hit_v;
  logic [NSLV-1:0][ADDR_W-1:0]  base_a, mask_a;
  logic [NSLV-1:0][DATA_W-1:0]  datao_a;

  assign base_a  = SLV_BASE;
  assign mask_a  = SLV_MASK;
  assign datao_a = slv_datao;

  genvar g;
  generate
    for (g = 0; g < NSLV; g++) begin : g_dec
      apb_mux_n_dec #(.ADDR_W(ADDR_W)) u_dec (
        .addr (apb_addr_cpu),
        .base (base_a[g]),
        .mask (mask_a[g]),
        .hit  (hit_v[g])
      );
    end
  endgenerate

  // Lowest index wins on overlapping windows: scan downward so the last
  // assignment is the smallest hitting index.
  always_comb begin
    idx_live = '0;
    for (int i = NSLV - 1; i >= 0; i--)
      if (hit_v[i]) idx_live = IDX_W'(i);
  end
  assign hit_live = |hit_v;

  assign slv_rw    = apb_rw_cpu;
  assign slv_addr  = apb_addr_cpu;
  assign slv_datai = apb_datai_cpu;

  // Saturating increment of the wait counter.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  // Completion path is purely combinational so a slave ack reaches the
  // master with no added latency.
  always_comb begin
    slv_psel      = '0;
    slv_enab      = '0;
    apb_ack_cpu   = 1'b0;
    apb_err_cpu   = 1'b0;
    apb_datao_cpu = '0;
    case (state)
      IDLE: begin
        // Setup cycle follows the live decode; held off while in reset.
        if (resetn && apb_psel_cpu && hit_live) slv_psel[idx_live] = 1'b1;
      end
      XFER: begin
        if (apb_psel_cpu) begin
          if (hit_q) begin
            slv_psel[idx_q] = 1'b1;
            slv_enab[idx_q] = apb_enab_cpu;
            if (apb_enab_cpu && slv_ack[idx_q]) begin
              apb_ack_cpu   = 1'b1;
              apb_datao_cpu = datao_a[idx_q];
            end
          end else if (apb_enab_cpu) begin
            apb_ack_cpu = 1'b1;
            apb_err_cpu = 1'b1;
          end
        end
      end
      TOUT: begin
        apb_ack_cpu = 1'b1;
        apb_err_cpu = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      idx_q    <= '0;
      hit_q    <= 1'b0;
      addr_q   <= '0;
      cnt      <= '0;
      err_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (apb_psel_cpu) begin
            state  <= XFER;
            idx_q  <= idx_live;
            hit_q  <= hit_live;
            addr_q <= apb_addr_cpu;
          end
        end
        XFER: begin
          if (!apb_psel_cpu) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (apb_ack_cpu) begin
            // A real ack beats a timeout landing in the same cycle.
            state <= IDLE;
            cnt   <= '0;
            if (apb_err_cpu) err_addr <= addr_q;
          end else if (apb_enab_cpu) begin
            cnt <= cnt_inc;
            if (TOUT_EN && cnt_inc >= LIM) state <= TOUT;
          end
        end
        TOUT: begin
          state    <= IDLE;
          cnt      <= '0;
          err_addr <= addr_q;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_mux_n.sv
module tb_apb_mux_n;
  localparam int NSLV = 9, AW = 32, DW = 32, TO_LIM = 4;
  // slave 8 .. slave 0
  localparam logic [NSLV*AW-1:0] BASE = {
    32'h2008_0000, 32'h2007_0000, 32'h2006_0000, 32'h1000_0000, 32'h2004_0000,
    32'hBFE4_0000, 32'h2002_0000, 32'h2001_0000, 32'h1000_0000};
  localparam logic [NSLV*AW-1:0] MASK = {
    32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_00FF, 32'h0000_FFFF,
    32'h0000_0FFF, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF};

  logic               clk = 1'b0;
  logic               resetn;
  logic               psel, enab, rw;
  logic [AW-1:0]      addr;
  logic [DW-1:0]      wdata;
  logic [DW-1:0]      apb_datao_cpu;
  logic               apb_ack_cpu, apb_err_cpu;
  logic [NSLV-1:0]    slv_psel, slv_enab, slv_ack;
  logic               slv_rw;
  logic [AW-1:0]      slv_addr, err_addr;
  logic [DW-1:0]      slv_datai;
  logic [NSLV*DW-1:0] slv_datao;

  apb_mux_n #(.NSLV(NSLV), .ADDR_W(AW), .DATA_W(DW), .SLV_BASE(BASE),
              .SLV_MASK(MASK), .TIMEOUT(TO_LIM)) dut (
    .clk(clk), .resetn(resetn),
    .apb_psel_cpu(psel), .apb_enab_cpu(enab), .apb_rw_cpu(rw),
    .apb_addr_cpu(addr), .apb_datai_cpu(wdata),
    .apb_datao_cpu(apb_datao_cpu), .apb_ack_cpu(apb_ack_cpu), .apb_err_cpu(apb_err_cpu),
    .slv_psel(slv_psel), .slv_enab(slv_enab), .slv_rw(slv_rw),
    .slv_addr(slv_addr), .slv_datai(slv_datai),
    .slv_datao(slv_datao), .slv_ack(slv_ack), .err_addr(err_addr));

  always #5 clk = ~clk;

  // Slave model: the selected slave acks on enable cycle number ack_at (0 = never).
  logic [DW-1:0] slv_data [NSLV];
  int ack_at = 0;
  int enab_cnt = 0;
  always @(posedge clk) enab_cnt <= (|slv_enab) ? enab_cnt + 1 : 0;
  always_comb begin
    slv_ack   = '0;
    slv_datao = '0;
    if (ack_at != 0 && enab_cnt == ack_at - 1) slv_ack = slv_enab;
    for (int i = 0; i < NSLV; i++) slv_datao[i*DW +: DW] = slv_data[i];
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic            rw;
    logic            err;
    logic [DW-1:0]   data;
    int              cyc;
    logic [NSLV-1:0] sel;
  } exp_t;
  exp_t sb[$];

  // Reference: first window (lowest index) containing the address, or -1.
  function automatic int decode(input logic [AW-1:0] a);
    int w = -1;
    for (int i = 0; i < NSLV; i++)
      if (w < 0 && (a & ~MASK[i*AW +: AW]) == BASE[i*AW +: AW]) w = i;
    return w;
  endfunction

  // Reference outcome: miss -> err on enable cycle 1; hit acked before the
  // limit -> data on that cycle; otherwise timeout error on cycle TO_LIM.
  function automatic exp_t model(input logic [AW-1:0] a, input logic r,
                                 input logic [DW-1:0] wd, input int aa);
    exp_t e;
    int w = decode(a);
    e.addr = a; e.rw = r; e.wdata = wd; e.sel = '0;
    if (w < 0) begin
      e.err = 1'b1; e.data = '0; e.cyc = 1;
    end else if (aa >= 1 && aa < TO_LIM) begin
      e.err = 1'b0; e.data = slv_data[w]; e.cyc = aa; e.sel[w] = 1'b1;
    end else begin
      e.err = 1'b1; e.data = '0; e.cyc = TO_LIM;
    end
    return e;
  endfunction

  // Monitor: compare every completion against the scoreboard head.
  int ecyc = 0;
  logic pend_err = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  always @(negedge clk) begin
    exp_t e;
    if (pend_err) begin
      chk("err_addr", 64'(err_addr), 64'(pend_addr));
      pend_err = 1'b0;
    end
    if (resetn && enab) ecyc++; else ecyc = 0;
    if (apb_ack_cpu) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL spurious_ack: got ack=1 expected no completion");
      end else begin
        e = sb.pop_front();
        chk("err",      64'(apb_err_cpu),   64'(e.err));
        chk("datao",    64'(apb_datao_cpu), 64'(e.data));
        chk("ack_cyc",  64'(ecyc),          64'(e.cyc));
        chk("slv_psel", 64'(slv_psel),      64'(e.sel));
        chk("slv_enab", 64'(slv_enab),      64'(e.sel));
        chk("slv_addr", 64'(slv_addr),      64'(e.addr));
        chk("slv_rw",   64'(slv_rw),        64'(e.rw));
        chk("slv_wd",   64'(slv_datai),     64'(e.wdata));
        if (e.err) begin pend_err = 1'b1; pend_addr = e.addr; end
      end
    end
  end

  task automatic xfer(input logic [AW-1:0] a, input logic r, input logic [DW-1:0] wd, input int aa);
    logic [NSLV-1:0] ssel = '0;
    int w = decode(a);
    int n = 0;
    if (w >= 0) ssel[w] = 1'b1;
    ack_at = aa;
    sb.push_back(model(a, r, wd, aa));
    @(posedge clk); #1;
    psel = 1'b1; enab = 1'b0; addr = a; rw = r; wdata = wd;
    @(negedge clk);
    chk("setup_sel", 64'(slv_psel), 64'(ssel));
    @(posedge clk); #1 enab = 1'b1;
    forever begin
      @(negedge clk);
      if (apb_ack_cpu) break;
      n++;
      if (n > 20) begin
        n_chk++; n_fail++;
        $display("FAIL ack_wait: got no ack in 20 cycles expected completion");
        break;
      end
    end
    @(posedge clk); #1 psel = 1'b0; enab = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; psel = 1'b1; enab = 1'b0; rw = 1'b0; addr = 32'hBFE4_0010; wdata = '0;
    for (int i = 0; i < NSLV; i++) slv_data[i] = $urandom;
    slv_data[3] = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_psel",  64'(slv_psel), 0);
    chk("rst_enab",  64'(slv_enab), 0);
    chk("rst_ack",   64'(apb_ack_cpu), 0);
    chk("rst_err",   64'(apb_err_cpu), 0);
    chk("rst_erra",  64'(err_addr), 0);
    psel = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;

    xfer(32'hBFE4_0010, 1'b0, 32'h0, 3);             // slave 3, two wait states
    xfer(32'h0000_1000, 1'b1, 32'hCAFE_F00D, 1);     // unmapped write
    xfer(32'hBFE4_0ABC, 1'b0, 32'h0, 0);             // never acks -> timeout
    xfer(32'h2001_0004, 1'b1, 32'h5555_AAAA, TO_LIM - 1); // ack in the limit cycle
    xfer(32'h1000_0042, 1'b0, 32'h0, 1);             // overlaps slaves 0 and 5

    // Abort: drop psel mid-transfer after two enable cycles.
    ack_at = 0;
    @(posedge clk); #1 psel = 1'b1; enab = 1'b0; addr = 32'h2002_0010; rw = 1'b1;
    @(posedge clk); #1 enab = 1'b1;
    repeat (2) begin @(negedge clk); chk("abort_ack", 64'(apb_ack_cpu), 0); end
    @(posedge clk); #1 psel = 1'b0; enab = 1'b0;
    @(negedge clk);
    chk("abort_ack2", 64'(apb_ack_cpu), 0);
    chk("abort_sel",  64'(slv_psel), 0);
    xfer(32'h2002_0010, 1'b0, 32'h0, 0);             // full timeout: counter restarted

    // Reset pulsed inside an access phase.
    ack_at = 0;
    @(posedge clk); #1 psel = 1'b1; enab = 1'b0; addr = 32'hBFE4_0020; rw = 1'b0;
    @(posedge clk); #1 enab = 1'b1;
    @(negedge clk); chk("pre_rst_sel", 64'(slv_psel), 64'(9'h008));
    @(posedge clk); #1 resetn = 1'b0; #1;
    chk("rstx_psel", 64'(slv_psel), 0);
    chk("rstx_enab", 64'(slv_enab), 0);
    chk("rstx_ack",  64'(apb_ack_cpu), 0);
    chk("rstx_err",  64'(apb_err_cpu), 0);
    chk("rstx_dat",  64'(apb_datao_cpu), 0);
    chk("rstx_erra", 64'(err_addr), 0);
    @(posedge clk); #1 psel = 1'b0; enab = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      int k = $urandom_range(0, NSLV);
      logic [AW-1:0] a;
      slv_data[$urandom_range(0, NSLV - 1)] = $urandom;
      if (k == NSLV) a = 32'h3000_0000 | ($urandom & 32'h0000_FFFF);
      else           a = BASE[k*AW +: AW] | ($urandom & MASK[k*AW +: AW]);
      xfer(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 5));
    end

    for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
    repeat (2) @(negedge clk);
    chk("sb_drain", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
